// File: rtl/debug_serial_fifo_pkg.sv
// Shared definitions for the debug serial FIFO stage: TX sequencer states and default FIFO size.
package debug_serial_fifo_pkg;

    localparam int DEF_FIFO_AW = 4;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_BUSY  = 2'd2,
        T_DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/debug_serial_fifo_byte_fifo.sv
// Synchronous byte FIFO with registered head data and registered full/empty flags.
module byte_fifo
    import debug_serial_fifo_pkg::*;
#(
    parameter int fifo_aw = DEF_FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 2 ** fifo_aw;
    localparam logic [fifo_aw:0] PTR_ONE  = {{fifo_aw{1'b0}}, 1'b1};
    localparam logic [fifo_aw:0] FULL_XOR = {1'b1, {fifo_aw{1'b0}}};

    logic [7:0]       mem_r [DEPTH];
    logic [fifo_aw:0] wr_ptr_r;
    logic [fifo_aw:0] rd_ptr_r;
    logic [fifo_aw:0] wr_nxt_s;
    logic [fifo_aw:0] rd_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic [7:0]       rdata_r;
    logic [7:0]       head_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify operations and compute next pointers and next head byte.
    always_comb begin
        do_pop_s   = pop & ~empty_r;
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        do_push_s  = push & (~full_r | pop);
        wr_nxt_s   = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_nxt_s   = do_pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        if (do_push_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s[fifo_aw-1:0]];
        end
    end

    // Storage array; contents need no reset since flags gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[fifo_aw-1:0]] <= wdata;
        end
    end

    // Pointers, flags and head register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            rdata_r  <= 8'h00;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            full_r   <= ((wr_nxt_s ^ rd_nxt_s) == FULL_XOR);
            empty_r  <= (wr_nxt_s == rd_nxt_s);
            if (do_push_s || do_pop_s) begin
                rdata_r <= head_nxt_s;
            end
        end
    end

    assign rdata = rdata_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/debug_serial_fifo.sv
// Byte buffering between the CPU debug port and the debug_serial UART core:
// TX queue with start/idle sequencing, RX capture queue, overrun and interrupt flags.
module debug_serial_fifo
    import debug_serial_fifo_pkg::*;
#(
    parameter int fifo_aw = DEF_FIFO_AW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_rd,
    output logic [7:0] cpu_rdata,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       rx_overrun,
    input  logic       clr_overrun,
    output logic       irq,
    output logic       uart_start,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_idle,
    input  logic       uart_rx_ready,
    input  logic [7:0] uart_rx_data
);

    tx_state_e  state_r;
    tx_state_e  state_nxt_s;
    logic       tx_pop_s;
    logic       start_nxt_s;
    logic [7:0] tx_head_s;
    logic       start_r;
    logic [7:0] tx_data_r;
    logic       rx_ready_r;
    logic       rx_capture_s;
    logic       rx_drop_s;
    logic       overrun_r;
    logic       irq_r;

    byte_fifo #(.fifo_aw(fifo_aw)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_wr),
        .wdata (cpu_wdata),
        .pop   (tx_pop_s),
        .rdata (tx_head_s),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.fifo_aw(fifo_aw)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_capture_s),
        .wdata (uart_rx_data),
        .pop   (cpu_rd),
        .rdata (cpu_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // TX sequencer next state; T_BUSY waits for the UART to leave idle so a stale idle cannot retrigger.
    always_comb begin
        state_nxt_s = state_r;
        tx_pop_s    = 1'b0;
        start_nxt_s = 1'b0;
        case (state_r)
            T_IDLE: begin
                if (uart_tx_idle && !tx_empty) begin
                    state_nxt_s = T_START;
                    tx_pop_s    = 1'b1;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = T_IDLE;
                end
            end
            T_START: state_nxt_s = T_BUSY;
            T_BUSY: begin
                if (!uart_tx_idle) begin
                    state_nxt_s = T_DONE;
                end else begin
                    state_nxt_s = T_BUSY;
                end
            end
            T_DONE: begin
                if (uart_tx_idle) begin
                    state_nxt_s = T_IDLE;
                end else begin
                    state_nxt_s = T_DONE;
                end
            end
            default: state_nxt_s = T_IDLE;
        endcase
    end

    // TX sequencer state, start strobe and held transmit byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= T_IDLE;
            start_r   <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            start_r <= start_nxt_s;
            if (tx_pop_s) begin
                tx_data_r <= tx_head_s;
            end
        end
    end

    // Rising-edge detect on the UART ready level and overrun qualification.
    always_comb begin
        rx_capture_s = uart_rx_ready & ~rx_ready_r;
        rx_drop_s    = rx_capture_s & rx_full & ~cpu_rd;
    end

    // Ready history (reset high to ignore a UART leaving reset with ready set), overrun and irq.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_r <= 1'b1;
            overrun_r  <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            rx_ready_r <= uart_rx_ready;
            if (rx_drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end
            irq_r <= ~rx_empty | overrun_r;
        end
    end

    assign uart_start   = start_r;
    assign uart_tx_data = tx_data_r;
    assign rx_overrun   = overrun_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_debug_serial_fifo.sv
// Directed bench for debug_serial_fifo with a small UART transmitter model.
module tb_debug_serial_fifo;

    logic       clk;
    logic       rst;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd;
    logic [7:0] cpu_rdata;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_overrun;
    logic       clr_overrun;
    logic       irq;
    logic       uart_start;
    logic [7:0] uart_tx_data;
    logic       uart_tx_idle;
    logic       uart_rx_ready;
    logic [7:0] uart_rx_data;

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    int viol_busy = 0;
    int viol_width = 0;
    int pending_cnt = 0;
    int busy_cnt = 0;
    int hold_cycles = 1;
    int frame_cycles = 100;
    int base = 0;
    logic stall = 1'b0;
    logic prev_start = 1'b0;
    logic [7:0] sent_q [$];

    debug_serial_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rd       (cpu_rd),
        .cpu_rdata    (cpu_rdata),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_overrun   (rx_overrun),
        .clr_overrun  (clr_overrun),
        .irq          (irq),
        .uart_start   (uart_start),
        .uart_tx_data (uart_tx_data),
        .uart_tx_idle (uart_tx_idle),
        .uart_rx_ready(uart_rx_ready),
        .uart_rx_data (uart_rx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // UART transmitter model: idle stays high hold_cycles after a start, then low for frame_cycles.
    initial begin
        uart_tx_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_start) begin
                if (prev_start) begin
                    viol_width++;
                end else if (!uart_tx_idle || pending_cnt != 0 || busy_cnt != 0) begin
                    viol_busy++;
                end
                n_starts++;
                sent_q.push_back(uart_tx_data);
                pending_cnt = hold_cycles;
                busy_cnt = 0;
            end else if (stall) begin
                uart_tx_idle = 1'b0;
            end else if (pending_cnt > 0) begin
                pending_cnt--;
                if (pending_cnt == 0) begin
                    uart_tx_idle = 1'b0;
                    busy_cnt = frame_cycles;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) uart_tx_idle = 1'b1;
            end else begin
                uart_tx_idle = 1'b1;
            end
            prev_start = uart_start;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sent_at(input int idx);
        if (idx < sent_q.size()) return 32'(sent_q[idx]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_wdata = d;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        @(negedge clk);
        uart_rx_data = d;
        uart_rx_ready = 1'b1;
        @(negedge clk);
        uart_rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input logic [7:0] e);
        check("rx_head", 32'(cpu_rdata), 32'(e));
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int target, input int limit);
        int k = 0;
        while (!(n_starts >= target && uart_tx_idle && pending_cnt == 0 && busy_cnt == 0
                 && tx_empty) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("tx_wait_timeout", 32'(k >= limit), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        cpu_wr = 1'b0;
        cpu_wdata = 8'h00;
        cpu_rd = 1'b0;
        clr_overrun = 1'b0;
        uart_rx_ready = 1'b1;
        uart_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state with UART ready held high
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_rx_full", 32'(rx_full), 32'd0);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        check("rst_tx_full", 32'(tx_full), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        uart_rx_ready = 1'b0;
        @(negedge clk);

        // two bytes, idle drops one cycle after start
        base = n_starts;
        push(8'h55);
        push(8'hA3);
        wait_tx(base + 2, 2000);
        check("tx2_count", 32'(n_starts - base), 32'd2);
        check("tx2_byte0", sent_at(base), 32'h55);
        check("tx2_byte1", sent_at(base + 1), 32'hA3);
        check("tx2_empty", 32'(tx_empty), 32'd1);

        // idle lingers high three cycles after start
        hold_cycles = 3;
        base = n_starts;
        push(8'h11);
        push(8'h22);
        wait_tx(base + 2, 2000);
        check("hold_count", 32'(n_starts - base), 32'd2);
        check("hold_byte0", sent_at(base), 32'h11);
        check("hold_byte1", sent_at(base + 1), 32'h22);
        hold_cycles = 1;

        // fill TX while the UART is stalled
        stall = 1'b1;
        repeat (2) @(negedge clk);
        base = n_starts;
        for (int i = 0; i < 15; i++) push(8'(i));
        check("tx_full_15", 32'(tx_full), 32'd0);
        push(8'h0F);
        check("tx_full_16", 32'(tx_full), 32'd1);
        push(8'h10);
        check("tx_full_17", 32'(tx_full), 32'd1);
        check("stall_no_start", 32'(n_starts - base), 32'd0);
        stall = 1'b0;
        wait_tx(base + 16, 4000);
        for (int i = 0; i < 16; i++) check("tx16_order", sent_at(base + i), 32'(i));
        repeat (300) @(negedge clk);
        check("tx16_count", 32'(n_starts - base), 32'd16);
        check("tx16_empty", 32'(tx_empty), 32'd1);
        check("start_while_busy", 32'(viol_busy), 32'd0);
        check("start_width", 32'(viol_width), 32'd0);

        // RX overrun after 17 captures
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h80 + i));
        check("rx_full_16", 32'(rx_full), 32'd1);
        check("rx_ovr_16", 32'(rx_overrun), 32'd0);
        rx_byte(8'h90);
        check("rx_ovr_17", 32'(rx_overrun), 32'd1);
        check("rx_irq_17", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) pop_expect(8'(8'h80 + i));
        check("rx_drained", 32'(rx_empty), 32'd1);
        check("irq_ovr_only", 32'(irq), 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(rx_overrun), 32'd0);
        check("irq_cleared", 32'(irq), 32'd0);

        // capture and pop together while full
        for (int i = 0; i < 16; i++) rx_byte(8'(8'h40 + i));
        check("rx_full_b", 32'(rx_full), 32'd1);
        @(negedge clk);
        uart_rx_data = 8'hEE;
        uart_rx_ready = 1'b1;
        cpu_rd = 1'b1;
        @(negedge clk);
        uart_rx_ready = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clk);
        check("simul_no_ovr", 32'(rx_overrun), 32'd0);
        check("simul_full", 32'(rx_full), 32'd1);
        for (int i = 1; i < 16; i++) pop_expect(8'(8'h40 + i));
        pop_expect(8'hEE);
        check("simul_drained", 32'(rx_empty), 32'd1);

        // pop while empty is ignored
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        @(negedge clk);
        check("empty_pop", 32'(rx_empty), 32'd1);
        rx_byte(8'h5A);
        check("after_empty_pop_ne", 32'(rx_empty), 32'd0);
        pop_expect(8'h5A);
        check("final_empty", 32'(rx_empty), 32'd1);
        @(negedge clk);
        check("final_irq", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_serial_fifo.md
Name: debug_serial_fifo

Overview:
- Byte-buffering stage between the CPU debug port and the debug_serial UART core.
- TX side queues CPU-written bytes and feeds them to the UART one at a time with the start/idle handshake.
- RX side captures each byte the UART completes and queues it for the CPU.
- Status flags and an RX overrun flag give the CPU polling or interrupt visibility.

Parameters:
- fifo_aw, 4, address width of each FIFO; depth = 2**fifo_aw entries (16).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- cpu_wr  in  1  push cpu_wdata into TX FIFO this cycle.
- cpu_wdata  in  8  byte to transmit.
- cpu_rd  in  1  pop RX FIFO head this cycle.
- cpu_rdata  out  8  RX FIFO head; valid when rx_empty=0.
- tx_full  out  1  TX FIFO full.
- tx_empty  out  1  TX FIFO empty.
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- rx_overrun  out  1  sticky: a received byte was dropped.
- clr_overrun  in  1  clears rx_overrun.
- irq  out  1  registered; equals (!rx_empty | rx_overrun).
- uart_start  out  1  to UART start_trasmit.
- uart_tx_data  out  8  to UART tx_data.
- uart_tx_idle  in  1  from UART transmitint; 1 = transmitter idle.
- uart_rx_ready  in  1  from UART ready_recive; level, rises when a byte completes.
- uart_rx_data  in  8  from UART rx_data.

Behaviour:
- Reset (rst=0, async): both FIFOs empty (pointers 0), tx_empty=1, rx_empty=1, tx_full=0, rx_full=0, rx_overrun=0, irq=0, uart_start=0, uart_tx_data=0, cpu_rdata=0, TX FSM in T_IDLE, rx_ready_q=1. Initialising rx_ready_q to 1 suppresses a false capture if the UART leaves reset with ready high.
- FIFOs: synchronous, registered-output, pointers fifo_aw+1 bits wide with a wrap bit.
  - full when the pointers are equal except for the MSB; empty when they are fully equal.
  - Push while full: ignored, no pointer change. Pop while empty: ignored.
  - Simultaneous push and pop when not empty and not full: both happen and the count is unchanged.
  - Simultaneous push and pop when empty: only the push happens.
  - Simultaneous push and pop when full: both happen.
  - Flags update one cycle after the operation.
- TX FSM, registered:
  - T_IDLE: if uart_tx_idle=1 and tx_empty=0, load uart_tx_data from the TX FIFO head, pop the FIFO, set uart_start=1, go to T_START.
  - T_START: uart_start=1 for exactly this one cycle; next state is T_BUSY and uart_start returns to 0.
  - T_BUSY: wait for uart_tx_idle=0, then go to T_DONE. This guards against re-issuing a start while the UART still shows idle in the cycle after the start.
  - T_DONE: wait for uart_tx_idle=1, then go to T_IDLE.
  - uart_tx_data holds its value until the next load.
  - Minimum start-to-start gap is 4 cycles plus the UART frame time.
- RX capture:
  - rx_ready_q <= uart_rx_ready every cycle.
  - Capture on a 0→1 transition: uart_rx_ready=1 and rx_ready_q=0.
  - On capture, push uart_rx_data if rx_full=0; otherwise drop the byte and set rx_overrun=1.
  - If a capture and a cpu_rd occur in the same cycle while full, the push succeeds (pop frees the slot) and no overrun is flagged.
- rx_overrun: set has priority over clr_overrun in the same cycle.
- cpu_rdata: shows the RX head; updates the cycle after a push into an empty FIFO or after a pop.
- Reset mid-frame: the FSM aborts to T_IDLE and queued bytes are lost. The UART has its own reset, so no recovery handshake is required.

Decomposition:
- Shared package/include: TX state encodings (T_IDLE=0, T_START=1, T_BUSY=2, T_DONE=3) and the default fifo_aw.
- One sub-module: byte_fifo (parameterised by fifo_aw), instantiated twice, once for TX and once for RX.
- The TX FSM, edge detector and flag logic stay in the top level.

Test Plan:
- Reset with uart_rx_ready held at 1 → no RX push, rx_empty=1, rx_overrun=0, uart_start=0.
- Push 0x55 and 0xA3 with the UART model idle; the model drops idle 1 cycle after start and holds it low for 100 cycles → exactly two 1-cycle uart_start pulses with data 0x55 then 0xA3, the second only after idle returns; tx_empty=1 at the end.
- Hold uart_tx_idle=1 for 3 cycles after start before it drops → no second pulse until idle has gone 0 then 1.
- Push 17 bytes 0x00..0x10 with the UART stalled (idle=0) → tx_full=1 after 16, the 17th is ignored, and 16 bytes are later sent in order 0x00..0x0F.
- 17 uart_rx_ready rising edges with data 0x80+i and no cpu_rd → rx_full=1, rx_overrun=1, irq=1; 16 pops return 0x80..0x8F; clr_overrun then clears the flag and irq=0.
- Capture edge plus cpu_rd in the same cycle while rx_full=1 → no overrun, rx_full stays 1, the head advances by one entry.
